// File: rtl/ph_cache_reader.sv
// Drains one stored pulse-height frame from the PH cache B port and streams it
// out as a 16-bit AXI-stream, with a credit-controlled FIFO hiding read latency.
module ph_cache_reader #(
    parameter int FRAME_WORDS = 256,
    parameter int RD_LAT      = 1,
    parameter int FIFO_DEPTH  = 4,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_rdy,
    input  logic              axi_cache_read,
    output logic              cache_enb,
    output logic [7:0]        cache_raddr,
    input  logic [DATA_W-1:0] cache_data,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        ovr_cnt
);
    localparam int            PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int            CW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [7:0]    LAST_ADDR = 8'(FRAME_WORDS - 1);
    localparam logic [PW-1:0] PTR_MAX   = PW'(FIFO_DEPTH - 1);
    localparam logic [CW:0]   DEPTH_C   = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t            state_q;
    logic              pending_q, busy_q, done_q;
    logic [7:0]        raddr_q, ovr_q;

    logic [RD_LAT-1:0] vld_q, vld_d, lst_q, lst_d;
    logic [DATA_W-1:0] fifo_dat [FIFO_DEPTH];
    logic              fifo_lst [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     cnt_q, cnt_d, inflight;
    logic [CW:0]       occ;
    logic              credit, issue, push, pop;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PW'(1);
    endfunction

    // Credit uses the registered FIFO count, so a pop frees space one cycle later.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(vld_q[i]);
        occ      = {1'b0, cnt_q} + {1'b0, inflight};
        credit   = occ < DEPTH_C;
        issue    = (state_q == READ) && credit;
        push     = vld_q[RD_LAT-1];
        pop      = m_axis_tvalid && m_axis_tready;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        vld_d    = '0;
        lst_d    = '0;
        vld_d[0] = issue;
        lst_d[0] = issue && (raddr_q == LAST_ADDR);
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            lst_d[i] = lst_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            raddr_q   <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (frame_rdy && pending_q)
                ovr_q <= sat_inc8(ovr_q);
            else if (frame_rdy)
                pending_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if ((pending_q || frame_rdy) && !axi_cache_read) begin
                        state_q   <= READ;
                        raddr_q   <= '0;
                        pending_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                READ: begin
                    if (issue) begin
                        if (raddr_q == LAST_ADDR) begin
                            state_q <= DRAIN;
                            raddr_q <= '0;
                        end else begin
                            raddr_q <= raddr_q + 8'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_d == '0 && vld_d == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read-return stage: tag pipeline and FIFO occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            vld_q <= vld_d;
            cnt_q <= cnt_d;
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        lst_q <= lst_d;
        if (push) begin
            fifo_dat[wr_ptr_q] <= cache_data;
            fifo_lst[wr_ptr_q] <= lst_q[RD_LAT-1];
        end
    end

    // Output stage: head entry is masked while empty so a flushed FIFO shows zeros.
    assign cache_enb     = issue;
    assign cache_raddr   = raddr_q;
    assign m_axis_tvalid = (cnt_q != '0);
    assign m_axis_tdata  = m_axis_tvalid ? fifo_dat[rd_ptr_q] : '0;
    assign m_axis_tlast  = m_axis_tvalid && fifo_lst[rd_ptr_q];
    assign busy          = busy_q;
    assign frame_done    = done_q;
    assign ovr_cnt       = ovr_q;

endmodule
